// File: rtl/count_sequencer.sv
// Round-robin sequencer that drives a mod-20 up/down counter for two requesters.
// Optional stall input `pause` is compiled in when CNT_SEQ_PAUSE_EN is defined.
module count_sequencer (
    input  logic       mclk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       dir_a,
    input  logic [4:0] len_a,
    input  logic       req_b,
    input  logic       dir_b,
    input  logic [4:0] len_b,
`ifdef CNT_SEQ_PAUSE_EN
    input  logic       pause,
`endif
    output logic       start,
    output logic       ud,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done_a,
    output logic       done_b,
    output logic [4:0] pos
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2,
        StRst    = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       dir_r, dir_d;
    logic [4:0] rem, rem_d;
    logic [1:0] grant_q, grant_d;
    logic       last_b, last_b_d;
    logic [4:0] pos_q, pos_d;
    logic       pick_b;
    logic       hold;
    logic [4:0] pos_step;

`ifdef CNT_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Requester not served last wins a tie; last_b=1 means B was served last.
    assign pick_b = req_b && (!req_a || !last_b);

    always_comb begin
        if (dir_r) begin
            pos_step = (pos_q == 5'd0) ? 5'd19 : pos_q - 5'd1;
        end else begin
            pos_step = (pos_q == 5'd19) ? 5'd0 : pos_q + 5'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_r;
        rem_d    = rem;
        grant_d  = grant_q;
        last_b_d = last_b;
        pos_d    = pos_q;
        case (state_q)
            StIdle, StRst: begin
                state_d = StIdle;
                grant_d = 2'b00;
                if (req_a || req_b) begin
                    dir_d   = pick_b ? dir_b : dir_a;
                    rem_d   = pick_b ? len_b : len_a;
                    grant_d = {pick_b, !pick_b};
                    if (rem_d != 5'd0) begin
                        state_d = StRun;
                    end else begin
                        state_d  = StFinish;
                        last_b_d = pick_b;
                    end
                end
            end
            StRun: begin
                if (!hold) begin
                    rem_d = rem - 5'd1;
                    pos_d = pos_step;
                    if (rem == 5'd1) begin
                        state_d  = StFinish;
                        last_b_d = grant_q[1];
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= StIdle;
            dir_r   <= 1'b0;
            rem     <= 5'd0;
            grant_q <= 2'b00;
            last_b  <= 1'b1;
            pos_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            dir_r   <= dir_d;
            rem     <= rem_d;
            grant_q <= grant_d;
            last_b  <= last_b_d;
            pos_q   <= pos_d;
        end
    end

    // Outputs decode registered state; pause only gates start while running.
    assign start  = (state_q == StRun) && !hold;
    assign ud     = (state_q == StRun) && dir_r;
    assign grant  = ((state_q == StRun) || (state_q == StFinish)) ? grant_q : 2'b00;
    assign busy   = (state_q == StRun) || (state_q == StFinish);
    assign done_a = (state_q == StFinish) && grant_q[0];
    assign done_b = (state_q == StFinish) && grant_q[1];
    assign pos    = pos_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer; pause scenario runs when
// CNT_SEQ_PAUSE_EN is defined.
module tb_count_sequencer;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, dir_a = 1'b0;
    logic [4:0] len_a = 5'd0;
    logic       req_b = 1'b0, dir_b = 1'b0;
    logic [4:0] len_b = 5'd0;
`ifdef CNT_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       start, ud, busy, done_a, done_b;
    logic [1:0] grant;
    logic [4:0] pos;

    int checks = 0;
    int failures = 0;

    count_sequencer dut (
        .mclk   (mclk),
        .reset  (reset),
        .req_a  (req_a),
        .dir_a  (dir_a),
        .len_a  (len_a),
        .req_b  (req_b),
        .dir_b  (dir_b),
        .len_b  (len_b),
`ifdef CNT_SEQ_PAUSE_EN
        .pause  (pause),
`endif
        .start  (start),
        .ud     (ud),
        .grant  (grant),
        .busy   (busy),
        .done_a (done_a),
        .done_b (done_b),
        .pos    (pos)
    );

    always #5 mclk = ~mclk;

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({start, ud, grant, busy, done_a, done_b, pos} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got s=%b ud=%b g=%b busy=%b da=%b db=%b pos=%0d exp all 0",
                     start, ud, grant, busy, done_a, done_b, pos);
        end
    endtask

    task automatic test_basic_up;
        do_reset();
        req_a = 1'b1; dir_a = 1'b0; len_a = 5'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (grant !== 2'b01 || start !== 1'b1 || ud !== 1'b0 || pos !== 5'(i) ||
                done_a !== 1'b0) begin
                failures++;
                $display("FAIL basic_run[%0d] got g=%b s=%b ud=%b pos=%0d da=%b exp g=01 s=1 ud=0 pos=%0d da=0",
                         i, grant, start, ud, pos, done_a, i);
            end
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || start !== 1'b0 || grant !== 2'b01 || pos !== 5'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_finish got da=%b s=%b g=%b pos=%0d busy=%b exp da=1 s=0 g=01 pos=5 busy=1",
                     done_a, start, grant, pos, busy);
        end
        req_a = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done_a !== 1'b0 || grant !== 2'b00 || pos !== 5'd5) begin
            failures++;
            $display("FAIL basic_idle got busy=%b da=%b g=%b pos=%0d exp busy=0 da=0 g=00 pos=5",
                     busy, done_a, grant, pos);
        end
    endtask

    task automatic test_down_wrap;
        logic [4:0] exp_pos [3];
        exp_pos = '{5'd0, 5'd19, 5'd18};
        do_reset();
        req_b = 1'b1; dir_b = 1'b1; len_b = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 2'b10 || start !== 1'b1 || ud !== 1'b1 || pos !== exp_pos[i] ||
                done_b !== 1'b0) begin
                failures++;
                $display("FAIL down_run[%0d] got g=%b s=%b ud=%b pos=%0d db=%b exp g=10 s=1 ud=1 pos=%0d db=0",
                         i, grant, start, ud, pos, done_b, exp_pos[i]);
            end
        end
        tick();
        checks++;
        if (done_b !== 1'b1 || done_a !== 1'b0 || grant !== 2'b10 || pos !== 5'd17 || start !== 1'b0) begin
            failures++;
            $display("FAIL down_finish got db=%b da=%b g=%b pos=%0d s=%b exp db=1 da=0 g=10 pos=17 s=0",
                     done_b, done_a, grant, pos, start);
        end
        req_b = 1'b0;
        tick();
        checks++;
        if (done_b !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL down_idle got db=%b busy=%b exp db=0 busy=0", done_b, busy);
        end
    endtask

    task automatic test_tie;
        logic [1:0] exp_g [16];
        logic       ea, eb;
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00,
                  2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
        do_reset();
        req_a = 1'b1; dir_a = 1'b0; len_a = 5'd2;
        req_b = 1'b1; dir_b = 1'b0; len_b = 5'd2;
        for (int i = 0; i < 16; i++) begin
            tick();
            ea = (i == 2) || (i == 10);
            eb = (i == 6) || (i == 14);
            checks++;
            if (grant !== exp_g[i] || busy !== (exp_g[i] != 2'b00) || done_a !== ea ||
                done_b !== eb) begin
                failures++;
                $display("FAIL tie[%0d] got g=%b busy=%b da=%b db=%b exp g=%b busy=%b da=%b db=%b",
                         i, grant, busy, done_a, done_b, exp_g[i], exp_g[i] != 2'b00, ea, eb);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
    endtask

    task automatic test_zero_len;
        do_reset();
        req_b = 1'b1; dir_b = 1'b0; len_b = 5'd3;
        for (int i = 0; i < 4; i++) tick();
        req_b = 1'b0;
        tick();
        req_a = 1'b1; dir_a = 1'b1; len_a = 5'd0;
        tick();
        checks++;
        if (done_a !== 1'b1 || start !== 1'b0 || grant !== 2'b01 || pos !== 5'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_finish got da=%b s=%b g=%b pos=%0d busy=%b exp da=1 s=0 g=01 pos=3 busy=1",
                     done_a, start, grant, pos, busy);
        end
        req_a = 1'b0;
        tick();
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || pos !== 5'd3 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle got s=%b busy=%b pos=%0d da=%b exp s=0 busy=0 pos=3 da=0",
                     start, busy, pos, done_a);
        end
    endtask

    task automatic test_reset_mid_run;
        int bad;
        do_reset();
        req_a = 1'b1; dir_a = 1'b0; len_a = 5'd10;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (start !== 1'b1 || pos !== 5'd2) begin
            failures++;
            $display("FAIL rst_run3 got s=%b pos=%0d exp s=1 pos=2", start, pos);
        end
        reset = 1'b1;
        req_a = 1'b0;
        tick();
        checks++;
        if (start !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || pos !== 5'd0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort got s=%b g=%b busy=%b pos=%0d da=%b exp s=0 g=00 busy=0 pos=0 da=0",
                     start, grant, busy, pos, done_a);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_no_done got %0d bad cycles exp 0", bad);
        end
    endtask

`ifdef CNT_SEQ_PAUSE_EN
    task automatic test_pause;
        int  starts;
        bit  seen_done;
        do_reset();
        pause = 1'b0;
        req_a = 1'b1; dir_a = 1'b0; len_a = 5'd6;
        starts = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            tick();
            pause = (c >= 1 && c <= 4);
            #1;
            if (pause) begin
                checks++;
                if (start !== 1'b0 || pos !== 5'd1) begin
                    failures++;
                    $display("FAIL pause_hold[%0d] got s=%b pos=%0d exp s=0 pos=1", c, start, pos);
                end
            end
            if (start === 1'b1) starts++;
            if (done_a === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (pos !== 5'd6) begin
                    failures++;
                    $display("FAIL pause_final_pos got %0d exp 6", pos);
                end
            end
        end
        pause = 1'b0;
        req_a = 1'b0;
        checks++;
        if (!seen_done || starts != 6) begin
            failures++;
            $display("FAIL pause_starts got starts=%0d done=%0b exp starts=6 done=1", starts, seen_done);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_up();
        test_down_wrap();
        test_tie();
        test_zero_len();
        test_reset_mid_run();
`ifdef CNT_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
